// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-op codes and fetch-stage defaults.
package cpu_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_J    = 2'd2,
    BR_JR   = 2'd3
  } br_op_e;

  localparam logic [31:0] PC_INIT_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF = 32'h0000_4180;
  localparam logic [31:0] NOP         = 32'h0000_0000;

endpackage

// File: rtl/npc_sel.sv
// Next-PC selection: sequential pc_q+4 or the branch target computed from the ID-stage PC.
module npc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc_q,
  input  logic [31:0] id_pc,
  input  logic [1:0]  br_op,
  input  logic [15:0] br_imm16,
  input  logic [25:0] j_imm26,
  input  logic [31:0] jr_target,
  input  logic        redirect,
  output logic [31:0] npc
);

  logic [31:0] id_pc4;
  logic [31:0] br_off;
  logic [31:0] target;

  always_comb begin
    id_pc4 = id_pc + 32'd4;
    br_off = {{14{br_imm16[15]}}, br_imm16, 2'b00};
    target = pc_q + 32'd4;
    case (br_op)
      BR_COND: target = id_pc4 + br_off;
      BR_J:    target = {id_pc4[31:28], j_imm26, 2'b00};
      BR_JR:   target = jr_target;
      default: target = pc_q + 32'd4;
    endcase
    npc = redirect ? target : (pc_q + 32'd4);
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, fetch-exception
// detection (misaligned or out-of-window PC) and a saturating fetch counter.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_INIT    = PC_INIT_DEF,
  parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DELAY_SLOT = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_rdata,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        br_op,
  input  logic              br_taken,
  input  logic [15:0]       br_imm16,
  input  logic [25:0]       j_imm26,
  input  logic [31:0]       jr_target,
  output logic [31:0]       pc,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc4,
  output logic              id_valid,
  output logic              id_exc,
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      id_instr_q, id_instr_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic             id_valid_q, id_valid_d;
  logic             id_exc_q, id_exc_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

  logic        redirect;
  logic [31:0] npc;
  logic [31:0] win_off;
  logic        fetch_exc;

  assign redirect = (br_op == BR_J) || (br_op == BR_JR) ||
                    ((br_op == BR_COND) && br_taken);

  npc_sel u_npc_sel (
    .pc_q      (pc_q),
    .id_pc     (id_pc_q),
    .br_op     (br_op),
    .br_imm16  (br_imm16),
    .j_imm26   (j_imm26),
    .jr_target (jr_target),
    .redirect  (redirect),
    .npc       (npc)
  );

  // Window is [PC_INIT, PC_INIT + 4*2^ADDR_W): offset must have no bits above ADDR_W+1.
  assign win_off   = pc_q - PC_INIT;
  assign fetch_exc = (pc_q[1:0] != 2'b00) || (pc_q < PC_INIT) ||
                     ((win_off >> (ADDR_W + 2)) != '0);

  assign im_addr = pc_q[ADDR_W+1:2];

  always_comb begin
    pc_d        = pc_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;
    id_exc_d    = id_exc_q;
    fetch_cnt_d = fetch_cnt_q;
    if (flush) begin
      pc_d       = EXC_VEC;
      id_instr_d = NOP;
      id_valid_d = 1'b0;
      id_exc_d   = 1'b0;
    end else if (!stall) begin
      pc_d = npc;
      if (redirect && (DELAY_SLOT == 0)) begin
        id_instr_d = NOP;
        id_valid_d = 1'b0;
        id_exc_d   = 1'b0;
      end else begin
        id_instr_d = fetch_exc ? NOP : im_rdata;
        id_pc_d    = pc_q;
        id_valid_d = 1'b1;
        id_exc_d   = fetch_exc;
        if (fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= PC_INIT;
      id_instr_q  <= NOP;
      id_pc_q     <= PC_INIT;
      id_valid_q  <= 1'b0;
      id_exc_q    <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
      id_exc_q    <= id_exc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign pc        = pc_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc_q + 32'd4;
  assign id_valid  = id_valid_q;
  assign id_exc    = id_exc_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (delay slot on with a 6-bit counter, delay slot off
// with a 32-bit counter) share stimulus; a reference model feeds a scoreboard queue per DUT.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [31:0] PCI = 32'h0000_3000;
  localparam logic [31:0] EV  = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        stall = 1'b0, flush = 1'b0, br_taken = 1'b0;
  logic [1:0]  br_op = 2'd0;
  logic [15:0] br_imm16 = '0;
  logic [25:0] j_imm26 = '0;
  logic [31:0] jr_target = '0;

  logic [11:0] im_addr0, im_addr1;
  logic [31:0] im_rdata0, im_rdata1;
  logic [31:0] pc0, pc1, id_instr0, id_instr1, id_pc0, id_pc1, id_pc40, id_pc41;
  logic        id_valid0, id_valid1, id_exc0, id_exc1;
  logic [5:0]  cnt0;
  logic [31:0] cnt1;

  function automatic logic [31:0] imf(input logic [11:0] a);
    return {a, 4'h5, ~a, 4'hA};
  endfunction

  assign im_rdata0 = imf(im_addr0);
  assign im_rdata1 = imf(im_addr1);

  fetch_stage #(.PC_INIT(PCI), .EXC_VEC(EV), .ADDR_W(12), .DELAY_SLOT(1), .CNT_W(6)) u_ds1 (
    .clk(clk), .reset(reset), .im_addr(im_addr0), .im_rdata(im_rdata0),
    .stall(stall), .flush(flush), .br_op(br_op), .br_taken(br_taken),
    .br_imm16(br_imm16), .j_imm26(j_imm26), .jr_target(jr_target),
    .pc(pc0), .id_instr(id_instr0), .id_pc(id_pc0), .id_pc4(id_pc40),
    .id_valid(id_valid0), .id_exc(id_exc0), .fetch_cnt(cnt0)
  );

  fetch_stage #(.PC_INIT(PCI), .EXC_VEC(EV), .ADDR_W(12), .DELAY_SLOT(0), .CNT_W(32)) u_ds0 (
    .clk(clk), .reset(reset), .im_addr(im_addr1), .im_rdata(im_rdata1),
    .stall(stall), .flush(flush), .br_op(br_op), .br_taken(br_taken),
    .br_imm16(br_imm16), .j_imm26(j_imm26), .jr_target(jr_target),
    .pc(pc1), .id_instr(id_instr1), .id_pc(id_pc1), .id_pc4(id_pc41),
    .id_valid(id_valid1), .id_exc(id_exc1), .fetch_cnt(cnt1)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        valid;
    logic        exc;
    logic [31:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per DUT.
  logic [31:0] m_pc[2], m_instr[2], m_ipc[2], m_cnt[2];
  logic        m_valid[2], m_exc[2];
  logic [31:0] cmax[2] = '{32'd63, 32'hFFFF_FFFF};
  int          ds[2] = '{1, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = PCI; m_instr[k] = 32'h0; m_ipc[k] = PCI;
      m_valid[k] = 1'b0; m_exc[k] = 1'b0; m_cnt[k] = 32'h0;
    end
  endtask

  task automatic push(input int k);
    exp_t e;
    e.pc = m_pc[k]; e.instr = m_instr[k]; e.ipc = m_ipc[k];
    e.valid = m_valid[k]; e.exc = m_exc[k]; e.cnt = m_cnt[k];
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic bubble(input int k);
    m_instr[k] = 32'h0; m_valid[k] = 1'b0; m_exc[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    logic [31:0] tgt, ip4, cur;
    logic        redir, ex;
    longint      p;
    cur   = m_pc[k];
    ip4   = m_ipc[k] + 32'd4;
    redir = (br_op == 2'd2) || (br_op == 2'd3) || (br_op == 2'd1 && br_taken);
    case (br_op)
      2'd1:    tgt = ip4 + 32'(4 * int'($signed(br_imm16)));
      2'd2:    tgt = (ip4 & 32'hF000_0000) | (32'(j_imm26) * 32'd4);
      default: tgt = jr_target;
    endcase
    p  = longint'(cur);
    ex = (p % 4 != 0) || (p < longint'(PCI)) || (p >= longint'(PCI) + 4 * 4096);
    if (flush) begin
      m_pc[k] = EV;
      bubble(k);
    end else if (!stall) begin
      m_pc[k] = redir ? tgt : cur + 32'd4;
      if (redir && ds[k] == 0) begin
        bubble(k);
      end else begin
        m_instr[k] = ex ? 32'h0 : imf(12'((cur >> 2) & 32'hFFF));
        m_ipc[k]   = cur;
        m_valid[k] = 1'b1;
        m_exc[k]   = ex;
        if (m_cnt[k] != cmax[k]) m_cnt[k] = m_cnt[k] + 32'd1;
      end
    end
  endtask

  task automatic step(input logic st, input logic fl, input logic [1:0] op, input logic tk,
                      input logic [15:0] imm, input logic [25:0] j, input logic [31:0] jr);
    @(negedge clk);
    reset = 1'b1;
    stall = st; flush = fl; br_op = op; br_taken = tk;
    br_imm16 = imm; j_imm26 = j; jr_target = jr;
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      push(k);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc0"}, pc0, PCI);
    chk({tag, "_pc1"}, pc1, PCI);
    chk({tag, "_idpc0"}, id_pc0, PCI);
    chk({tag, "_instr0"}, id_instr0, 32'h0);
    chk({tag, "_valid0"}, 32'(id_valid0), 32'h0);
    chk({tag, "_valid1"}, 32'(id_valid1), 32'h0);
    chk({tag, "_exc0"}, 32'(id_exc0), 32'h0);
    chk({tag, "_cnt0"}, 32'(cnt0), 32'h0);
    chk({tag, "_cnt1"}, cnt1, 32'h0);
  endtask

  // Assert reset between edges; outputs must clear before the next rising edge.
  task automatic mid_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_state("async_rst");
    model_reset();
    push(0);
    push(1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("sb0_pc", pc0, e.pc);
        chk("sb0_instr", id_instr0, e.instr);
        chk("sb0_valid", 32'(id_valid0), 32'(e.valid));
        chk("sb0_exc", 32'(id_exc0), 32'(e.exc));
        chk("sb0_cnt", 32'(cnt0), e.cnt);
        if (e.valid) begin
          chk("sb0_idpc", id_pc0, e.ipc);
          chk("sb0_idpc4", id_pc40, e.ipc + 32'd4);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("sb1_pc", pc1, e.pc);
        chk("sb1_instr", id_instr1, e.instr);
        chk("sb1_valid", 32'(id_valid1), 32'(e.valid));
        chk("sb1_exc", 32'(id_exc1), 32'(e.exc));
        chk("sb1_cnt", cnt1, e.cnt);
        if (e.valid) begin
          chk("sb1_idpc", id_pc1, e.ipc);
          chk("sb1_idpc4", id_pc41, e.ipc + 32'd4);
        end
      end
    end
  end

  initial begin : driver
    int r;
    logic [1:0] op;
    logic [31:0] jr;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_reset_state("por");

    // Sequential fetch after reset release.
    idle(); after_edge(); chk("seq_idpc_a", id_pc0, 32'h3000); chk("seq_valid_a", 32'(id_valid0), 32'h1);
    idle(); after_edge(); chk("seq_idpc_b", id_pc0, 32'h3004);
    idle(); after_edge(); chk("seq_idpc_c", id_pc0, 32'h3008); chk("seq_cnt", 32'(cnt0), 32'd3);

    // Taken COND at id_pc=0x3004: delay slot kept (u_ds1) or squashed (u_ds0).
    mid_reset();
    idle(); idle();
    step(1'b0, 1'b0, 2'd1, 1'b1, 16'h0003, 26'h0, 32'h0); after_edge();
    chk("cond_pc", pc0, 32'h3014);
    chk("ds1_slot_idpc", id_pc0, 32'h3008);
    chk("ds1_slot_valid", 32'(id_valid0), 32'h1);
    chk("ds0_bubble_valid", 32'(id_valid1), 32'h0);
    chk("ds0_bubble_instr", id_instr1, 32'h0);
    idle(); after_edge();
    chk("cond_tgt_idpc0", id_pc0, 32'h3014);
    chk("cond_tgt_idpc1", id_pc1, 32'h3014);
    step(1'b0, 1'b0, 2'd1, 1'b0, 16'h0003, 26'h0, 32'h0); after_edge();
    chk("cond_nt_pc", pc1, 32'h301C);
    chk("cond_nt_valid", 32'(id_valid1), 32'h1);

    // J held under stall, then taken once.
    mid_reset();
    idle();
    step(1'b1, 1'b0, 2'd2, 1'b0, 16'h0, 26'h0000C10, 32'h0); after_edge();
    chk("stall_pc_a", pc0, 32'h3004); chk("stall_idpc_a", id_pc0, 32'h3000);
    step(1'b1, 1'b0, 2'd2, 1'b0, 16'h0, 26'h0000C10, 32'h0); after_edge();
    chk("stall_pc_b", pc0, 32'h3004); chk("stall_cnt_b", 32'(cnt0), 32'd1);
    step(1'b0, 1'b0, 2'd2, 1'b0, 16'h0, 26'h0000C10, 32'h0); after_edge();
    chk("j_pc", pc0, 32'h3040);
    idle(); after_edge();
    chk("j_idpc", id_pc0, 32'h3040);

    // Flush wins over a simultaneous stall.
    step(1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h3010); after_edge();
    chk("jr_pc", pc0, 32'h3010);
    step(1'b1, 1'b1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0); after_edge();
    chk("flush_pc0", pc0, EV); chk("flush_pc1", pc1, EV);
    chk("flush_valid0", 32'(id_valid0), 32'h0); chk("flush_valid1", 32'(id_valid1), 32'h0);

    // Fetch exceptions: misaligned JR target and out-of-window PC.
    step(1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h3002);
    idle(); after_edge();
    chk("mis_exc0", 32'(id_exc0), 32'h1); chk("mis_instr0", id_instr0, 32'h0);
    chk("mis_idpc0", id_pc0, 32'h3002); chk("mis_exc1", 32'(id_exc1), 32'h1);
    step(1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h7000);
    idle(); after_edge();
    chk("oow_exc0", 32'(id_exc0), 32'h1); chk("oow_idpc0", id_pc0, 32'h7000);

    // Randomized traffic; targets mostly land inside the window.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      op = (r < 55) ? 2'd0 : (r < 75) ? 2'd1 : (r < 85) ? 2'd2 : 2'd3;
      case ($urandom_range(0, 9))
        0:       jr = 32'h7000 + ($urandom_range(0, 255) << 2);
        1:       jr = 32'h2FF0 + 32'($urandom_range(0, 15));
        2:       jr = 32'h3000 + 32'($urandom_range(0, 16383));
        default: jr = 32'h3000 + ($urandom_range(0, 4095) << 2);
      endcase
      step($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, op, 1'($urandom_range(0, 1)),
           16'($signed($urandom_range(0, 63)) - 32), 26'($urandom_range(12'hC00, 16'h1BFF)), jr);
    end
    after_edge();
    chk("cnt_saturated", 32'(cnt0), 32'd63);

    @(posedge clk); #3;
    @(posedge clk); #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
